// File: rtl/framebuffer_read_arbiter.sv
// framebuffer_read_arbiter
// Shares the framebuffer RAM read port between the display pixel fetch and a
// secondary readback requester. The display always wins and is never delayed;
// the secondary path gets a one-deep request/response handshake that only uses
// cycles in which the display leaves the port idle.
module framebuffer_read_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WAIT   = 64,
  parameter int WAIT_WIDTH = 8
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  disp_enable,
  input  logic [ADDR_WIDTH-1:0] disp_address,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  output logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_clk_enable,
  input  logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  starved
);

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    ISSUED
  } state_t;

  localparam logic [WAIT_WIDTH-1:0] WAIT_LIMIT = WAIT_WIDTH'(MAX_WAIT);
  localparam logic [WAIT_WIDTH-1:0] WAIT_LAST  = WAIT_WIDTH'(MAX_WAIT - 1);
  localparam logic [WAIT_WIDTH-1:0] WAIT_ONE   = WAIT_WIDTH'(1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [WAIT_WIDTH-1:0] wait_cnt;
  logic                  issue_now;

  // The secondary read takes the port only when it is waiting and the display
  // is idle; reset forces pass-through regardless of the current state.
  assign issue_now = !reset && (state == PENDING) && !disp_enable;

  assign rd_ready = (state == IDLE);

  // RAM port mux: pass-through to the display unless a pending read is issued.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    ram_address    = disp_address;
    ram_clk_enable = disp_enable;
    if (issue_now) begin
      ram_address    = pend_addr;
      ram_clk_enable = 1'b1;
    end
  end

  // Request FSM with registered handshake outputs and the starvation monitor.
  always_ff @(posedge clk_in) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values
    // and the block models flops rather than a chain of combinational updates.
    if (reset) begin
      state     <= IDLE;
      pend_addr <= '0;
      wait_cnt  <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      starved   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          // Accept only; issuing waits until at least the next cycle.
          if (rd_req) begin
            pend_addr <= rd_address;
            wait_cnt  <= '0;
            state     <= PENDING;
          end
        end
        PENDING: begin
          if (disp_enable) begin
            // Display owns the port: count the lost cycle, saturating.
            if (wait_cnt != WAIT_LIMIT) begin
              wait_cnt <= wait_cnt + WAIT_ONE;
            end
            // Sticky: set on the edge where the count reaches the limit.
            if (wait_cnt >= WAIT_LAST) begin
              starved <= 1'b1;
            end
          end else begin
            state <= ISSUED;
          end
        end
        ISSUED: begin
          // RAM data now reflects the address enabled on the previous edge,
          // so display use of the port in this cycle cannot corrupt it.
          rd_data  <= ram_data_in;
          rd_valid <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_read_arbiter.sv
// tb_framebuffer_read_arbiter
// Directed scenarios plus a randomized run against a transaction-level model
// of the arbiter; a behavioural one-cycle-latency RAM sits on the port.
module tb_framebuffer_read_arbiter;

  localparam int AW = 11;
  localparam int DW = 16;
  localparam int MW = 4;

  logic          clk_in;
  logic          reset;
  logic          disp_enable;
  logic [AW-1:0] disp_address;
  logic          rd_req;
  logic [AW-1:0] rd_address;
  logic          rd_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] ram_address;
  logic          ram_clk_enable;
  logic [DW-1:0] ram_data_in;
  logic          starved;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_checks;
  int n_pass;

  framebuffer_read_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_WAIT  (MW),
    .WAIT_WIDTH(8)
  ) dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .disp_enable   (disp_enable),
    .disp_address  (disp_address),
    .rd_req        (rd_req),
    .rd_address    (rd_address),
    .rd_ready      (rd_ready),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .ram_address   (ram_address),
    .ram_clk_enable(ram_clk_enable),
    .ram_data_in   (ram_data_in),
    .starved       (starved)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Framebuffer RAM: registered read, data valid one clock after an enable.
  always @(posedge clk_in) begin
    if (ram_clk_enable) ram_data_in <= mem[ram_address];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One edge with reset high, returning at a negedge with inputs idle.
  task automatic apply_reset();
    @(negedge clk_in);
    reset = 1'b1; disp_enable = 1'b0; rd_req = 1'b0;
    @(negedge clk_in);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk_in);
    reset = 1'b1; disp_enable = 1'b1; disp_address = 11'h3C3; rd_req = 1'b0;
    #1;
    n_checks++;
    if ({ram_clk_enable, ram_address} !== {1'b1, 11'h3C3})
      $display("FAIL reset_passthru: got ce=%b addr=%h want ce=1 addr=3c3", ram_clk_enable, ram_address);
    else n_pass++;
    @(negedge clk_in);
    #1;
    n_checks++;
    if ({rd_ready, rd_valid, rd_data, starved} !== {1'b1, 1'b0, 16'h0000, 1'b0})
      $display("FAIL reset_values: got ready=%b valid=%b data=%h starved=%b want 1 0 0000 0",
               rd_ready, rd_valid, rd_data, starved);
    else n_pass++;
    disp_enable = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_solo_read();
    apply_reset();
    disp_address = 11'h7FF; rd_req = 1'b1; rd_address = 11'h2A5;
    @(negedge clk_in);                       // cycle 0..1
    rd_req = 1'b0; rd_address = 11'h000;
    #1;
    n_checks++;
    if ({ram_clk_enable, ram_address, rd_ready} !== {1'b1, 11'h2A5, 1'b0})
      $display("FAIL solo_issue: got ce=%b addr=%h ready=%b want 1 2a5 0", ram_clk_enable, ram_address, rd_ready);
    else n_pass++;
    @(negedge clk_in); #1;                   // cycle 1..2
    n_checks++;
    if ({ram_clk_enable, ram_address, rd_ready, rd_valid} !== {1'b0, 11'h7FF, 1'b0, 1'b0})
      $display("FAIL solo_issued: got ce=%b addr=%h ready=%b valid=%b want 0 7ff 0 0",
               ram_clk_enable, ram_address, rd_ready, rd_valid);
    else n_pass++;
    @(negedge clk_in); #1;                   // cycle 2..3
    n_checks++;
    if ({rd_valid, rd_data, rd_ready} !== {1'b1, 16'hBEEF, 1'b1})
      $display("FAIL solo_valid: got valid=%b data=%h ready=%b want 1 beef 1", rd_valid, rd_data, rd_ready);
    else n_pass++;
    @(negedge clk_in); #1;                   // cycle 3..4
    n_checks++;
    if ({rd_valid, rd_data} !== {1'b0, 16'hBEEF})
      $display("FAIL solo_hold: got valid=%b data=%h want 0 beef", rd_valid, rd_data);
    else n_pass++;
  endtask

  task automatic test_display_during_issued();
    apply_reset();
    rd_req = 1'b1; rd_address = 11'h0F0;
    @(negedge clk_in);                       // cycle 0..1: issue
    rd_req = 1'b0;
    @(negedge clk_in);                       // cycle 1..2: ISSUED, display active
    disp_enable = 1'b1; disp_address = 11'h001;
    #1;
    n_checks++;
    if ({ram_clk_enable, ram_address} !== {1'b1, 11'h001})
      $display("FAIL issued_disp_mux: got ce=%b addr=%h want 1 001", ram_clk_enable, ram_address);
    else n_pass++;
    @(negedge clk_in);                       // cycle 2..3
    disp_enable = 1'b0;
    #1;
    n_checks++;
    if ({rd_valid, rd_data} !== {1'b1, 16'hCAFE})
      $display("FAIL issued_disp_data: got valid=%b data=%h want 1 cafe", rd_valid, rd_data);
    else n_pass++;
    n_checks++;
    if (ram_data_in !== 16'h1234)
      $display("FAIL issued_disp_word: got %h want 1234", ram_data_in);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    rd_req = 1'b1; rd_address = 11'h111;
    @(negedge clk_in);                       // cycle 0..1
    rd_address = 11'h222;                    // held request, must be ignored
    #1;
    n_checks++;
    if ({ram_clk_enable, ram_address, rd_ready} !== {1'b1, 11'h111, 1'b0})
      $display("FAIL b2b_first_issue: got ce=%b addr=%h ready=%b want 1 111 0", ram_clk_enable, ram_address, rd_ready);
    else n_pass++;
    @(negedge clk_in);                       // cycle 1..2
    @(negedge clk_in);                       // cycle 2..3
    rd_address = 11'h333;
    #1;
    n_checks++;
    if ({rd_valid, rd_data, rd_ready} !== {1'b1, 16'h1111, 1'b1})
      $display("FAIL b2b_first_valid: got valid=%b data=%h ready=%b want 1 1111 1", rd_valid, rd_data, rd_ready);
    else n_pass++;
    @(negedge clk_in);                       // cycle 3..4
    rd_req = 1'b0;
    #1;
    n_checks++;
    if ({rd_valid, ram_clk_enable, ram_address} !== {1'b0, 1'b1, 11'h333})
      $display("FAIL b2b_second_issue: got valid=%b ce=%b addr=%h want 0 1 333", rd_valid, ram_clk_enable, ram_address);
    else n_pass++;
    @(negedge clk_in);                       // cycle 4..5
    @(negedge clk_in); #1;                   // cycle 5..6
    n_checks++;
    if ({rd_valid, rd_data} !== {1'b1, 16'h3333})
      $display("FAIL b2b_second_valid: got valid=%b data=%h want 1 3333", rd_valid, rd_data);
    else n_pass++;
    @(negedge clk_in); #1;                   // cycle 6..7
    n_checks++;
    if ({rd_valid, rd_ready} !== {1'b0, 1'b1})
      $display("FAIL b2b_done: got valid=%b ready=%b want 0 1", rd_valid, rd_ready);
    else n_pass++;
  endtask

  task automatic test_ignored_request();
    int pulses;
    logic [DW-1:0] seen;
    apply_reset();
    rd_req = 1'b1; rd_address = 11'h444;
    @(negedge clk_in);                       // cycle 0..1: busy
    rd_req = 1'b0; disp_enable = 1'b1; disp_address = 11'h010;
    @(negedge clk_in);                       // cycle 1..2: busy, request while PENDING
    rd_req = 1'b1; rd_address = 11'h555;
    @(negedge clk_in);                       // cycle 2..3: busy
    rd_req = 1'b0;
    @(negedge clk_in);                       // cycle 3..4: idle, issue
    disp_enable = 1'b0;
    #1;
    n_checks++;
    if ({ram_clk_enable, ram_address, starved} !== {1'b1, 11'h444, 1'b0})
      $display("FAIL ignored_issue: got ce=%b addr=%h starved=%b want 1 444 0", ram_clk_enable, ram_address, starved);
    else n_pass++;
    pulses = 0;
    seen = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_in); #1;
      if (rd_valid === 1'b1) begin
        pulses++;
        seen = rd_data;
      end
    end
    n_checks++;
    if (pulses != 1 || seen !== 16'h4444)
      $display("FAIL ignored_count: got pulses=%0d data=%h want 1 4444", pulses, seen);
    else n_pass++;
    n_checks++;
    if (starved !== 1'b0)
      $display("FAIL ignored_not_starved: got %b want 0", starved);
    else n_pass++;
  endtask

  task automatic test_display_collision();
    int lat;
    bit found;
    apply_reset();
    rd_req = 1'b1; rd_address = 11'h666;
    @(negedge clk_in);                       // cycle 0..1
    rd_req = 1'b0;
    for (int b = 0; b < 5; b++) begin
      disp_enable = 1'b1; disp_address = 11'($urandom_range(2047, 0));
      #1;
      n_checks++;
      if ({ram_clk_enable, ram_address} !== {1'b1, disp_address})
        $display("FAIL collision_track: got ce=%b addr=%h want 1 %h", ram_clk_enable, ram_address, disp_address);
      else n_pass++;
      @(negedge clk_in);
    end
    disp_enable = 1'b0;                      // cycle 5..6: first idle cycle
    #1;
    n_checks++;
    if ({ram_clk_enable, ram_address} !== {1'b1, 11'h666})
      $display("FAIL collision_issue: got ce=%b addr=%h want 1 666", ram_clk_enable, ram_address);
    else n_pass++;
    lat = 5;
    found = 1'b0;
    while (!found && lat < 20) begin
      @(negedge clk_in); #1;
      lat++;
      if (rd_valid === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found || lat != 7 || rd_data !== 16'h6666)
      $display("FAIL collision_latency: got found=%b lat=%0d data=%h want 1 7 6666", found, lat, rd_data);
    else n_pass++;
  endtask

  task automatic test_starvation();
    int lat;
    bit found;
    apply_reset();
    rd_req = 1'b1; rd_address = 11'h777;
    @(negedge clk_in);                       // cycle 0..1
    rd_req = 1'b0;
    for (int b = 0; b < 10; b++) begin
      disp_enable = 1'b1; disp_address = 11'($urandom_range(2047, 0));
      #1;
      n_checks++;
      if ({starved, rd_valid} !== {(b >= MW), 1'b0})
        $display("FAIL starve_cycle%0d: got starved=%b valid=%b want %b 0", b, starved, rd_valid, (b >= MW));
      else n_pass++;
      @(negedge clk_in);
    end
    disp_enable = 1'b0;                      // cycle 10..11
    lat = 10;
    found = 1'b0;
    while (!found && lat < 30) begin
      @(negedge clk_in); #1;
      lat++;
      if (rd_valid === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found || lat != 12 || rd_data !== 16'h7777 || starved !== 1'b1)
      $display("FAIL starve_complete: got found=%b lat=%0d data=%h starved=%b want 1 12 7777 1",
               found, lat, rd_data, starved);
    else n_pass++;
    repeat (3) @(negedge clk_in);
    #1;
    n_checks++;
    if (starved !== 1'b1)
      $display("FAIL starve_sticky: got %b want 1", starved);
    else n_pass++;
    apply_reset();
    #1;
    n_checks++;
    if (starved !== 1'b0)
      $display("FAIL starve_cleared: got %b want 0", starved);
    else n_pass++;
  endtask

  task automatic test_reset_midop();
    int pulses;
    apply_reset();
    rd_req = 1'b1; rd_address = 11'h0AB;
    @(negedge clk_in); rd_req = 1'b0;        // cycle 0..1
    @(negedge clk_in);                       // cycle 1..2
    @(negedge clk_in); #1;                   // cycle 2..3
    n_checks++;
    if ({rd_valid, rd_data} !== {1'b1, 16'h0ABC})
      $display("FAIL midop_first: got valid=%b data=%h want 1 0abc", rd_valid, rd_data);
    else n_pass++;
    rd_req = 1'b1; rd_address = 11'h0CD;     // accepted at edge 3
    @(negedge clk_in); rd_req = 1'b0;        // cycle 3..4: issue
    @(negedge clk_in);                       // cycle 4..5: ISSUED, reset now
    reset = 1'b1; disp_enable = 1'b1; disp_address = 11'h055;
    #1;
    n_checks++;
    if ({ram_clk_enable, ram_address} !== {1'b1, 11'h055})
      $display("FAIL midop_issued_mux: got ce=%b addr=%h want 1 055", ram_clk_enable, ram_address);
    else n_pass++;
    @(negedge clk_in);
    reset = 1'b0; disp_enable = 1'b0; disp_address = 11'h066;
    #1;
    n_checks++;
    if ({rd_valid, rd_data, rd_ready, ram_clk_enable, ram_address} !== {1'b0, 16'h0000, 1'b1, 1'b0, 11'h066})
      $display("FAIL midop_after_reset: got valid=%b data=%h ready=%b ce=%b addr=%h want 0 0000 1 0 066",
               rd_valid, rd_data, rd_ready, ram_clk_enable, ram_address);
    else n_pass++;
    // Reset while PENDING with the display idle: must not issue.
    rd_req = 1'b1; rd_address = 11'h0EF;
    @(negedge clk_in);
    rd_req = 1'b0; reset = 1'b1;
    #1;
    n_checks++;
    if ({ram_clk_enable, ram_address} !== {1'b0, 11'h066})
      $display("FAIL midop_pending_mux: got ce=%b addr=%h want 0 066", ram_clk_enable, ram_address);
    else n_pass++;
    @(negedge clk_in);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in); #1;
      if (rd_valid !== 1'b0) pulses++;
    end
    n_checks++;
    if (pulses != 0 || rd_ready !== 1'b1)
      $display("FAIL midop_no_valid: got pulses=%0d ready=%b want 0 1", pulses, rd_ready);
    else n_pass++;
  endtask

  // Randomized run against a transaction-level model: an outstanding request
  // with its address, whether it has had its free RAM cycle, and how many
  // display-busy cycles it has waited. Expected read data is taken straight
  // from the memory contents at the requested address.
  task automatic test_random(input int n);
    bit            m_out;
    bit            m_got_slot;
    logic [AW-1:0] m_addr;
    int            m_wait;
    bit            m_starved;
    bit            m_valid;
    logic [DW-1:0] m_data;
    logic [AW-1:0] exp_addr;
    logic          exp_ce;
    int            errs;
    apply_reset();
    m_out = 0; m_got_slot = 0; m_addr = '0; m_wait = 0;
    m_starved = 0; m_valid = 0; m_data = '0;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      reset        = ($urandom_range(59, 0) == 0);
      disp_enable  = ($urandom_range(99, 0) < 60);
      disp_address = 11'($urandom_range(2047, 0));
      rd_req       = ($urandom_range(2, 0) == 0);
      rd_address   = 11'($urandom_range(2047, 0));
      #1;
      if (!reset && m_out && !m_got_slot && !disp_enable) begin
        exp_ce = 1'b1; exp_addr = m_addr;
      end else begin
        exp_ce = disp_enable; exp_addr = disp_address;
      end
      n_checks++;
      if ({ram_clk_enable, ram_address, rd_ready, rd_valid, rd_data, starved} !==
          {exp_ce, exp_addr, !m_out, m_valid, m_data, m_starved}) begin
        errs++;
        if (errs <= 10)
          $display("FAIL random_cycle%0d: got ce=%b addr=%h ready=%b valid=%b data=%h starved=%b want %b %h %b %b %h %b",
                   i, ram_clk_enable, ram_address, rd_ready, rd_valid, rd_data, starved,
                   exp_ce, exp_addr, !m_out, m_valid, m_data, m_starved);
      end else n_pass++;
      // Advance the model across the coming edge.
      if (reset) begin
        m_out = 0; m_got_slot = 0; m_wait = 0; m_starved = 0; m_valid = 0; m_data = '0;
      end else begin
        m_valid = 0;
        if (m_out && m_got_slot) begin
          m_data = mem[m_addr]; m_valid = 1; m_out = 0; m_got_slot = 0;
        end else if (m_out) begin
          if (disp_enable) begin
            if (m_wait < MW) m_wait++;
            if (m_wait >= MW) m_starved = 1;
          end else begin
            m_got_slot = 1;
          end
        end else if (rd_req) begin
          m_out = 1; m_addr = rd_address; m_wait = 0;
        end
      end
      @(negedge clk_in);
    end
    reset = 1'b0; disp_enable = 1'b0; rd_req = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1; disp_enable = 1'b0; disp_address = '0; rd_req = 1'b0; rd_address = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'($urandom);
    mem[11'h2A5] = 16'hBEEF; mem[11'h001] = 16'h1234; mem[11'h0F0] = 16'hCAFE;
    mem[11'h111] = 16'h1111; mem[11'h222] = 16'h2222; mem[11'h333] = 16'h3333;
    mem[11'h444] = 16'h4444; mem[11'h555] = 16'h5555; mem[11'h666] = 16'h6666;
    mem[11'h777] = 16'h7777; mem[11'h0AB] = 16'h0ABC; mem[11'h0CD] = 16'h0CDE;

    test_reset();
    test_solo_read();
    test_display_during_issued();
    test_back_to_back();
    test_ignored_request();
    test_display_collision();
    test_starvation();
    test_reset_midop();
    test_random(600);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
